// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle controller, datapath and ALU:
// states, opcodes, ALU op codes, function-field bits and mux selects.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_RD  = 4'd2,
    S_LOAD_WB = 4'd3,
    S_MEM_WR  = 4'd4,
    S_JMP     = 4'd5,
    S_BRZ     = 4'd6,
    S_EX_C    = 4'd7,
    S_WB_C    = 4'd8,
    S_EX_I    = 4'd9,
    S_WB_I    = 4'd10
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOTB  = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam int FN_MOVETO   = 0;
  localparam int FN_MOVEFROM = 1;
  localparam int FN_ADD      = 2;
  localparam int FN_SUB      = 3;
  localparam int FN_AND      = 4;
  localparam int FN_OR       = 5;
  localparam int FN_NOTB     = 6;
  localparam int FN_NOP      = 7;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] BSEL_REG = 2'd0;
  localparam logic [1:0] BSEL_IMM = 2'd1;
  localparam logic [1:0] BSEL_ONE = 2'd2;

  // A C-type result is written back only for a single set bit among 0..6.
  function automatic logic fn_writes(input logic [8:0] fn);
    logic [8:0] low;
    low = fn & (fn - 9'd1);
    return (fn != 9'd0) && (low == 9'd0) && (fn[8:7] == 2'b00);
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Instruction input and datapath control bundle between controller and datapath.
interface multi_cycle_controller_if;
  logic [15:0] IR_in;
  logic        pcWrite, pcWriteCtrl, IorD, MemRead, MemWrite, IRWrite, MemToReg, ALUsrc_A;
  logic        RegDst1, RegDst2, RegWrite1, RegWrite2;
  logic [1:0]  pcSRC;
  logic [1:0]  ALUsrc_B;
  logic [2:0]  ALUop2;
  logic [3:0]  state_out;

  modport master (
    input  IR_in,
    output pcWrite, pcWriteCtrl, IorD, MemRead, MemWrite, IRWrite, MemToReg, ALUsrc_A,
           RegDst1, RegDst2, RegWrite1, RegWrite2, pcSRC, ALUsrc_B, ALUop2, state_out
  );

  modport slave (
    output IR_in,
    input  pcWrite, pcWriteCtrl, IorD, MemRead, MemWrite, IRWrite, MemToReg, ALUsrc_A,
           RegDst1, RegDst2, RegWrite1, RegWrite2, pcSRC, ALUsrc_B, ALUop2, state_out
  );
endinterface

// File: rtl/multi_cycle_controller_alu_dec.sv
// ALU operation decode from (state, opcode, function field).
module ctrl_alu_decoder
  import multi_cycle_controller_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic [8:0] fn,
  output logic [2:0] aluop
);

  always_comb begin
    aluop = ALU_ADD;
    case (state)
      S_BRZ: aluop = ALU_PASSA;
      S_EX_C: begin
        // Non-one-hot fields fall back to PASSA; WB_C suppresses their write.
        aluop = ALU_PASSA;
        case (fn)
          9'(1 << FN_MOVETO):   aluop = ALU_PASSA;
          9'(1 << FN_MOVEFROM): aluop = ALU_PASSB;
          9'(1 << FN_ADD):      aluop = ALU_ADD;
          9'(1 << FN_SUB):      aluop = ALU_SUB;
          9'(1 << FN_AND):      aluop = ALU_AND;
          9'(1 << FN_OR):       aluop = ALU_OR;
          9'(1 << FN_NOTB):     aluop = ALU_NOTB;
          9'(1 << FN_NOP):      aluop = ALU_PASSA;
          default:              aluop = ALU_PASSA;
        endcase
      end
      S_EX_I: begin
        case (opcode[1:0])
          2'b00:   aluop = ALU_ADD;
          2'b01:   aluop = ALU_SUB;
          2'b10:   aluop = ALU_AND;
          default: aluop = ALU_OR;
        endcase
      end
      default: aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle instruction sequencer: one state register plus combinational
// next-state and control decode; all controls forced low while rst is high.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic                      clock,
  input  logic                      rst,
  multi_cycle_controller_if.master  bus
);

  state_t     state, state_nxt;
  logic [3:0] opcode;
  logic [8:0] fn;
  logic [2:0] aluop;
  logic       unused_ir_bits;

  logic       pc_write, pc_write_ctrl, iord, mem_read, mem_write, ir_write, mem_to_reg, alu_a;
  logic       reg_dst1, reg_write1, reg_write2;
  logic [1:0] pc_src, alu_b;

  assign opcode         = bus.IR_in[15:12];
  assign fn             = bus.IR_in[8:0];
  assign unused_ir_bits = ^bus.IR_in[11:9];

  always_ff @(posedge clock) begin
    if (rst) state <= S_IF;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = S_IF;
    pc_write      = 1'b0;
    pc_write_ctrl = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    alu_a         = 1'b0;
    reg_dst1      = 1'b0;
    reg_write1    = 1'b0;
    reg_write2    = 1'b0;
    pc_src        = PC_ALU;
    alu_b         = BSEL_REG;
    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_b     = BSEL_ONE;
        pc_src    = PC_ALU;
        pc_write  = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_LOAD:  state_nxt = S_MEM_RD;
          OP_STORE: state_nxt = S_MEM_WR;
          OP_JUMP:  state_nxt = S_JMP;
          OP_BRZ:   state_nxt = S_BRZ;
          OP_CTYPE: state_nxt = S_EX_C;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_nxt = S_EX_I;
          default:  state_nxt = S_IF;
        endcase
      end
      S_MEM_RD: begin
        iord      = 1'b1;
        mem_read  = 1'b1;
        state_nxt = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        mem_to_reg = 1'b1;
        reg_write2 = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_JMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      S_BRZ: begin
        // PC load is qualified by the datapath Zero flag.
        alu_a         = 1'b1;
        pc_src        = PC_BRANCH;
        pc_write_ctrl = 1'b1;
      end
      S_EX_C: begin
        alu_a     = 1'b1;
        alu_b     = BSEL_REG;
        state_nxt = S_WB_C;
      end
      S_WB_C: begin
        reg_write1 = fn_writes(fn);
        reg_dst1   = (fn == 9'(1 << FN_MOVETO));
      end
      S_EX_I: begin
        alu_a     = 1'b1;
        alu_b     = BSEL_IMM;
        state_nxt = S_WB_I;
      end
      S_WB_I: reg_write1 = 1'b1;
      default: state_nxt = S_IF;
    endcase
  end

  ctrl_alu_decoder u_alu_dec (
    .state  (state),
    .opcode (opcode),
    .fn     (fn),
    .aluop  (aluop)
  );

  // Gate with rst so an abandoned instruction issues no write on that edge.
  assign bus.pcWrite     = ~rst & pc_write;
  assign bus.pcWriteCtrl = ~rst & pc_write_ctrl;
  assign bus.IorD        = ~rst & iord;
  assign bus.MemRead     = ~rst & mem_read;
  assign bus.MemWrite    = ~rst & mem_write;
  assign bus.IRWrite     = ~rst & ir_write;
  assign bus.MemToReg    = ~rst & mem_to_reg;
  assign bus.ALUsrc_A    = ~rst & alu_a;
  assign bus.RegDst1     = ~rst & reg_dst1;
  assign bus.RegDst2     = 1'b0;
  assign bus.RegWrite1   = ~rst & reg_write1;
  assign bus.RegWrite2   = ~rst & reg_write2;
  assign bus.pcSRC       = rst ? 2'd0 : pc_src;
  assign bus.ALUsrc_B    = rst ? 2'd0 : alu_b;
  assign bus.ALUop2      = rst ? 3'd0 : aluop;
  assign bus.state_out   = state;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: per-cycle expected control vectors are queued when an
// instruction is driven and popped against the DUT each cycle.
module tb_multi_cycle_controller;
  import multi_cycle_controller_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  multi_cycle_controller_if bus ();

  multi_cycle_controller dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Vector: {state,pcWrite,pcWriteCtrl,IorD,MemRead,MemWrite,IRWrite,MemToReg,
  //          ALUsrc_A,RegDst1,RegDst2,RegWrite1,RegWrite2,pcSRC,ALUsrc_B,ALUop2}
  function automatic logic [22:0] model(input state_t st, input logic [15:0] ir, input logic r);
    logic pw, pwc, iod, mr, mw, irw, m2r, asa, rd1, rw1, rw2;
    logic [1:0] psrc, asb;
    logic [2:0] op;
    logic [8:0] fn;
    fn = ir[8:0];
    {pw, pwc, iod, mr, mw, irw, m2r, asa, rd1, rw1, rw2} = '0;
    psrc = 2'd0; asb = 2'd0; op = 3'b000;
    case (st)
      S_IF:      begin mr = 1; irw = 1; asb = 2'd2; pw = 1; end
      S_MEM_RD:  begin iod = 1; mr = 1; end
      S_LOAD_WB: begin m2r = 1; rw2 = 1; end
      S_MEM_WR:  begin iod = 1; mw = 1; end
      S_JMP:     begin psrc = 2'd2; pw = 1; end
      S_BRZ:     begin asa = 1; op = 3'b101; psrc = 2'd1; pwc = 1; end
      S_EX_C: begin
        asa = 1;
        case (fn)
          9'h001:  op = 3'b101;
          9'h002:  op = 3'b110;
          9'h004:  op = 3'b000;
          9'h008:  op = 3'b001;
          9'h010:  op = 3'b010;
          9'h020:  op = 3'b011;
          9'h040:  op = 3'b100;
          default: op = 3'b101;
        endcase
      end
      S_WB_C: begin
        rw1 = (fn == 9'h001) || (fn == 9'h002) || (fn == 9'h004) || (fn == 9'h008) ||
              (fn == 9'h010) || (fn == 9'h020) || (fn == 9'h040);
        rd1 = (fn == 9'h001);
      end
      S_EX_I: begin
        asa = 1; asb = 2'd1;
        case (ir[13:12])
          2'b00: op = 3'b000;
          2'b01: op = 3'b001;
          2'b10: op = 3'b010;
          default: op = 3'b011;
        endcase
      end
      S_WB_I: rw1 = 1;
      default: ;
    endcase
    if (r) return {st, 19'b0};
    return {st, pw, pwc, iod, mr, mw, irw, m2r, asa, rd1, 1'b0, rw1, rw2, psrc, asb, op};
  endfunction

  function automatic logic [22:0] observed();
    return {bus.state_out, bus.pcWrite, bus.pcWriteCtrl, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemToReg, bus.ALUsrc_A, bus.RegDst1, bus.RegDst2, bus.RegWrite1,
            bus.RegWrite2, bus.pcSRC, bus.ALUsrc_B, bus.ALUop2};
  endfunction

  // Called just after a negedge: compare, then advance one full cycle.
  task automatic step();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, {9'b0, observed()}, {9'b0, e.v});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input string tag, input state_t st, input logic [15:0] ir, input logic r);
    exp_t e;
    e.tag = tag;
    e.v   = model(st, ir, r);
    sb.push_back(e);
  endtask

  task automatic run_instr(input logic [15:0] ir);
    state_t seq[$];
    seq = {S_IF, S_ID};
    case (ir[15:12])
      4'b0000: begin seq.push_back(S_MEM_RD); seq.push_back(S_LOAD_WB); end
      4'b0001: seq.push_back(S_MEM_WR);
      4'b0010: seq.push_back(S_JMP);
      4'b0100: seq.push_back(S_BRZ);
      4'b1000: begin seq.push_back(S_EX_C); seq.push_back(S_WB_C); end
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin seq.push_back(S_EX_I); seq.push_back(S_WB_I); end
      default: ;
    endcase
    bus.IR_in = ir;
    foreach (seq[i]) push($sformatf("ir%h_c%0d", ir, i), seq[i], ir, 1'b0);
    repeat (seq.size()) step();
  endtask

  logic [15:0] prog[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IR_in = 16'h0000;
    rst = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    push("reset_hold", S_IF, 16'h0000, 1'b1);
    step();
    rst = 1'b0;

    prog = {16'h0005, 16'h1005, 16'h2123, 16'h4023, 16'h8204, 16'h8201, 16'h8203,
            16'h8202, 16'h8208, 16'h8210, 16'h8220, 16'h8240, 16'h8280, 16'h8200,
            16'h8300, 16'hC001, 16'hD00A, 16'hE000, 16'hF000, 16'h3000, 16'h0005};
    foreach (prog[i]) run_instr(prog[i]);

    // Abandon a STORE in MEM_WR: no write that cycle, IF after the edge.
    bus.IR_in = 16'h1005;
    push("midrst_if", S_IF, 16'h1005, 1'b0);
    push("midrst_id", S_ID, 16'h1005, 1'b0);
    step();
    step();
    rst = 1'b1;
    push("midrst_memwr", S_MEM_WR, 16'h1005, 1'b1);
    step();
    push("midrst_after", S_IF, 16'h1005, 1'b1);
    step();
    rst = 1'b0;
    run_instr(16'h8201);
    run_instr(16'h0005);

    push("final_if", S_IF, 16'h0005, 1'b0);
    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
